// File: rtl/clas_seq_ctrl_if.sv
// Request/response bundle between an ALU issue stage and the multi-beat add/sub sequencer.
interface clas_seq_ctrl_if #(
    parameter int unsigned WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic             op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             c_out;
    logic             ovf;

    // Requester / consumer side
    modport master (
        output in_valid, op, a, b, out_ready,
        input  in_ready, out_valid, result, c_out, ovf
    );

    // Sequencer side
    modport slave (
        input  in_valid, op, a, b, out_ready,
        output in_ready, out_valid, result, c_out, ovf
    );
endinterface

// File: rtl/clas_seq_ctrl.sv
// Multi-beat WIDTH-bit add/sub built on one shared 8-bit carry-look-ahead slice.
// One slice is processed per cycle with the carry registered between beats.

// 8-bit carry-look-ahead adder/subtractor; b is inverted internally when sel=1.
module clas_8bit (
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic       sel,
    input  logic       c_in,
    output logic [7:0] result,
    output logic       c_out
);
    logic [7:0] b_x;
    logic [7:0] g;
    logic [7:0] p;
    logic [8:0] c;
    logic       cy;
    logic       prop;

    // Flat generate/propagate look-ahead for every carry position
    always_comb begin
        b_x  = b ^ {8{sel}};
        g    = a & b_x;
        p    = a ^ b_x;
        c    = '0;
        cy   = 1'b0;
        prop = 1'b1;
        c[0] = c_in;
        for (int i = 0; i < 8; i++) begin
            cy   = 1'b0;
            prop = 1'b1;
            for (int j = i; j >= 0; j--) begin
                cy   = cy | (prop & g[j]);
                prop = prop & p[j];
            end
            c[i+1] = cy | (prop & c_in);
        end
        result = p ^ c[7:0];
        c_out  = c[8];
    end
endmodule

module clas_seq_ctrl #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned SLICE = 8
) (
    input  logic             clk,
    input  logic             rst,
    clas_seq_ctrl_if.slave   bus
);
    localparam int unsigned BEATS  = WIDTH / SLICE;
    localparam int unsigned BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             state_q;
    state_t             state_nxt;
    logic               accept;
    logic               last_beat;

    logic [BEAT_W-1:0]  beat_q;
    logic               carry_q;
    logic               op_q;
    logic [WIDTH-1:0]   a_q;
    logic [WIDTH-1:0]   b_q;
    logic [WIDTH-1:0]   result_q;
    logic               c_out_q;
    logic               ovf_q;
    logic               in_ready_q;
    logic               out_valid_q;

    logic [SLICE-1:0]   slice_a;
    logic [SLICE-1:0]   slice_b;
    logic [SLICE-1:0]   slice_res;
    logic               slice_c_out;
    logic               b_eff_msb;

    // Select the operand slice for the current beat
    always_comb begin
        slice_a   = SLICE'(a_q >> (SLICE * beat_q));
        slice_b   = SLICE'(b_q >> (SLICE * beat_q));
        b_eff_msb = b_q[WIDTH-1] ^ op_q;
    end

    clas_8bit u_slice (
        .a      (slice_a),
        .b      (slice_b),
        .sel    (op_q),
        .c_in   (carry_q),
        .result (slice_res),
        .c_out  (slice_c_out)
    );

    // Next-state and control decode
    always_comb begin
        state_nxt = state_q;
        accept    = 1'b0;
        last_beat = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.in_valid && in_ready_q) begin
                    accept    = 1'b1;
                    state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                last_beat = (beat_q == BEAT_W'(BEATS - 1));
                if (last_beat) begin
                    state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                if (bus.out_ready) begin
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_nxt;
        end
    end

    // Handshake flags registered from the next state so they track it exactly
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            in_ready_q  <= (state_nxt == S_IDLE);
            out_valid_q <= (state_nxt == S_DONE);
        end
    end

    // Operand capture, per-beat accumulate and final flag computation
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            beat_q   <= '0;
            carry_q  <= 1'b0;
            op_q     <= 1'b0;
            a_q      <= '0;
            b_q      <= '0;
            result_q <= '0;
            c_out_q  <= 1'b0;
            ovf_q    <= 1'b0;
        end else if (accept) begin
            op_q     <= bus.op;
            a_q      <= bus.a;
            b_q      <= bus.b;
            result_q <= '0;
            beat_q   <= '0;
            carry_q  <= bus.op;
        end else if (state_q == S_RUN) begin
            result_q <= result_q | (WIDTH'(slice_res) << (SLICE * beat_q));
            carry_q  <= slice_c_out;
            if (last_beat) begin
                c_out_q <= slice_c_out;
                ovf_q   <= (a_q[WIDTH-1] == b_eff_msb) &
                           (slice_res[SLICE-1] != a_q[WIDTH-1]);
            end else begin
                beat_q <= beat_q + BEAT_W'(1);
            end
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.result    = result_q;
    assign bus.c_out     = c_out_q;
    assign bus.ovf       = ovf_q;
endmodule
